// File: rtl/exu_mdu_ctrl.sv
// RV32M sequencing stage: drives the external multiplier, registers its result,
// and runs a one-bit-per-cycle restoring divider for DIV/DIVU/REM/REMU.
`ifndef RV32_DATA_WIDTH
`define RV32_DATA_WIDTH 32
`endif

module exu_mdu_ctrl #(
   parameter int DATA_WIDTH = `RV32_DATA_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid,
   input  logic [2:0]            i_funct3,
   input  logic [DATA_WIDTH-1:0] i_src1,
   input  logic [DATA_WIDTH-1:0] i_src2,
   input  logic                  i_flush,
   output logic [DATA_WIDTH-1:0] o_mul_src1,
   output logic [DATA_WIDTH-1:0] o_mul_src2,
   output logic                  o_mul_src1_signed,
   output logic                  o_mul_src2_signed,
   output logic                  o_mul_sel_high,
   input  logic [DATA_WIDTH-1:0] i_mul_dout,
   output logic                  o_stall,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_dout
);

   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {ST_IDLE, ST_DIV, ST_DONE} state_t;

   state_t                state_reg, state_next;
   logic [DATA_WIDTH-1:0] dout_reg, dout_next;
   logic [DATA_WIDTH-1:0] dvd_reg, dvd_next;
   logic [DATA_WIDTH-1:0] dvs_reg, dvs_next;
   logic [DATA_WIDTH-1:0] quo_reg, quo_next;
   logic [DATA_WIDTH:0]   rem_reg, rem_next;
   logic [CNT_W-1:0]      cnt_reg, cnt_next;
   logic                  neg_q_reg, neg_q_next;
   logic                  neg_r_reg, neg_r_next;
   logic                  op_rem_reg, op_rem_next;

   // Operand decode for an op waiting in IDLE
   logic                  is_div, is_signed, is_rem;
   logic                  sign1, sign2, div_zero, div_ovf;
   logic [DATA_WIDTH-1:0] abs1, abs2;

   assign is_div    = i_funct3[2];
   assign is_signed = ~i_funct3[0];
   assign is_rem    = i_funct3[1];
   assign sign1     = is_signed & i_src1[DATA_WIDTH-1];
   assign sign2     = is_signed & i_src2[DATA_WIDTH-1];
   assign abs1      = sign1 ? (~i_src1 + 1'b1) : i_src1;
   assign abs2      = sign2 ? (~i_src2 + 1'b1) : i_src2;
   assign div_zero  = (i_src2 == '0);
   assign div_ovf   = is_signed && (i_src1 == MIN_NEG) && (i_src2 == '1);

   // One restoring step: the trial subtraction borrows out of bit DATA_WIDTH when it fails
   logic [DATA_WIDTH:0]   rem_shift, rem_trial, rem_iter;
   logic [DATA_WIDTH-1:0] quo_iter, res_sel, res_final;
   logic                  trial_ok, res_neg;

   assign rem_shift = {rem_reg[DATA_WIDTH-1:0], dvd_reg[DATA_WIDTH-1]};
   assign rem_trial = rem_shift - {1'b0, dvs_reg};
   assign trial_ok  = ~rem_trial[DATA_WIDTH];
   assign rem_iter  = trial_ok ? rem_trial : rem_shift;
   assign quo_iter  = {quo_reg[DATA_WIDTH-2:0], trial_ok};
   assign res_sel   = op_rem_reg ? rem_iter[DATA_WIDTH-1:0] : quo_iter;
   assign res_neg   = op_rem_reg ? neg_r_reg : neg_q_reg;
   assign res_final = res_neg ? (~res_sel + 1'b1) : res_sel;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg  <= ST_IDLE;
         dout_reg   <= '0;
         dvd_reg    <= '0;
         dvs_reg    <= '0;
         quo_reg    <= '0;
         rem_reg    <= '0;
         cnt_reg    <= '0;
         neg_q_reg  <= 1'b0;
         neg_r_reg  <= 1'b0;
         op_rem_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         dout_reg   <= dout_next;
         dvd_reg    <= dvd_next;
         dvs_reg    <= dvs_next;
         quo_reg    <= quo_next;
         rem_reg    <= rem_next;
         cnt_reg    <= cnt_next;
         neg_q_reg  <= neg_q_next;
         neg_r_reg  <= neg_r_next;
         op_rem_reg <= op_rem_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      dout_next   = dout_reg;
      dvd_next    = dvd_reg;
      dvs_next    = dvs_reg;
      quo_next    = quo_reg;
      rem_next    = rem_reg;
      cnt_next    = cnt_reg;
      neg_q_next  = neg_q_reg;
      neg_r_next  = neg_r_reg;
      op_rem_next = op_rem_reg;

      case (state_reg)
         ST_IDLE: begin
            if (i_valid) begin
               if (!is_div) begin
                  dout_next  = i_mul_dout;
                  state_next = ST_DONE;
               end else if (div_zero) begin
                  dout_next  = is_rem ? i_src1 : '1;
                  state_next = ST_DONE;
               end else if (div_ovf) begin
                  dout_next  = is_rem ? '0 : MIN_NEG;
                  state_next = ST_DONE;
               end else begin
                  dvd_next    = abs1;
                  dvs_next    = abs2;
                  neg_q_next  = sign1 ^ sign2;
                  neg_r_next  = sign1;
                  op_rem_next = is_rem;
                  quo_next    = '0;
                  rem_next    = '0;
                  cnt_next    = '0;
                  state_next  = ST_DIV;
               end
            end
         end
         ST_DIV: begin
            rem_next = rem_iter;
            quo_next = quo_iter;
            dvd_next = {dvd_reg[DATA_WIDTH-2:0], 1'b0};
            cnt_next = cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_W'(DATA_WIDTH-1)) begin
               dout_next  = res_final;
               state_next = ST_DONE;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase

      // A killed op never reaches the output register
      if (i_flush) begin
         state_next = ST_IDLE;
         dout_next  = dout_reg;
      end
   end

   assign o_mul_src1        = i_src1;
   assign o_mul_src2        = i_src2;
   assign o_mul_src1_signed = ~i_funct3[2] & (i_funct3[1:0] != 2'b11);
   assign o_mul_src2_signed = ~i_funct3[2] & ~i_funct3[1];
   assign o_mul_sel_high    = ~i_funct3[2] & (i_funct3[1:0] != 2'b00);

   // Held low through reset so an op parked on i_valid cannot stall a reset pipeline
   assign o_stall = i_rst_n & ~i_flush &
                    (((state_reg == ST_IDLE) & i_valid) | (state_reg == ST_DIV));
   assign o_valid = (state_reg == ST_DONE);
   assign o_dout  = dout_reg;

endmodule

// File: tb/tb_exu_mdu_ctrl.sv
// Bench for exu_mdu_ctrl: directed and random M-extension ops checked against an
// arithmetic reference model, with a stand-in for the external multiplier.
`timescale 1ns/1ps

module tb_exu_mdu_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_valid;
   logic [2:0]  i_funct3;
   logic [31:0] i_src1, i_src2;
   logic        i_flush;
   logic [31:0] o_mul_src1, o_mul_src2;
   logic        o_mul_src1_signed, o_mul_src2_signed, o_mul_sel_high;
   logic [31:0] i_mul_dout;
   logic        o_stall, o_valid;
   logic [31:0] o_dout;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_exp;

   always #5 i_clk = ~i_clk;

   exu_mdu_ctrl #(.DATA_WIDTH(32)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_funct3(i_funct3),
      .i_src1(i_src1), .i_src2(i_src2), .i_flush(i_flush),
      .o_mul_src1(o_mul_src1), .o_mul_src2(o_mul_src2),
      .o_mul_src1_signed(o_mul_src1_signed), .o_mul_src2_signed(o_mul_src2_signed),
      .o_mul_sel_high(o_mul_sel_high), .i_mul_dout(i_mul_dout),
      .o_stall(o_stall), .o_valid(o_valid), .o_dout(o_dout)
   );

   // Stand-in for exu_mul: 33x33 signed product of the operands as the DUT presents them
   logic signed [32:0] mul_a, mul_b;
   logic signed [65:0] mul_p;
   assign mul_a      = {o_mul_src1_signed & o_mul_src1[31], o_mul_src1};
   assign mul_b      = {o_mul_src2_signed & o_mul_src2[31], o_mul_src2};
   assign mul_p      = mul_a * mul_b;
   assign i_mul_dout = o_mul_sel_high ? mul_p[63:32] : mul_p[31:0];

   function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, b);
      logic signed [63:0] sp;
      logic [63:0]        up;
      int                 sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      case (f)
         3'd0: begin up = 64'(a) * 64'(b); return up[31:0]; end
         3'd1: begin sp = 64'(sa) * 64'(sb); return sp[63:32]; end
         3'd2: begin sp = 64'(sa) * $signed({32'b0, b}); return sp[63:32]; end
         3'd3: begin up = 64'(a) * 64'(b); return up[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(sa / sb);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(sa % sb);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, b);
      if (!f[2] || b == 0) return 1;
      if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one op on the next negedge and follow it to its result cycle
   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
      logic [31:0] exp;
      int          lat;
      exp = ref_result(f, a, b);
      lat = ref_latency(f, a, b);
      @(negedge i_clk);
      i_valid = 1'b1; i_funct3 = f; i_src1 = a; i_src2 = b; i_flush = 1'b0;
      #1;
      chk({tag, "/dout_hold"}, o_dout, last_exp);
      chk({tag, "/msrc1"}, o_mul_src1, a);
      chk({tag, "/msrc2"}, o_mul_src2, b);
      if (!f[2]) begin
         chk({tag, "/ms1"}, 32'(o_mul_src1_signed), 32'(f != 3'd3));
         chk({tag, "/ms2"}, 32'(o_mul_src2_signed), 32'(f < 3'd2));
         chk({tag, "/mhi"}, 32'(o_mul_sel_high), 32'(f != 3'd0));
      end
      for (int c = 0; c <= lat; c++) begin
         if (c > 0) begin
            @(negedge i_clk);
            #1;
         end
         chk({tag, "/stall"}, 32'(o_stall), 32'(c < lat));
         chk({tag, "/valid"}, 32'(o_valid), 32'(c == lat));
      end
      chk({tag, "/dout"}, o_dout, exp);
      last_exp = exp;
      $display("txn %s f=%0d a=%h b=%h dout=%h expected=%h", tag, f, a, b, o_dout, exp);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      i_rst_n = 1'b0; i_valid = 1'b0; i_funct3 = 3'd0;
      i_src1 = '0; i_src2 = '0; i_flush = 1'b0;
      last_exp = '0;
      repeat (2) @(negedge i_clk);
      #1;
      chk("reset/valid", 32'(o_valid), 32'd0);
      chk("reset/dout", o_dout, 32'd0);
      chk("reset/stall", 32'(o_stall), 32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      do_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh_min");
      do_op(3'd0, 32'hFFFF_FFFF, 32'd3,         "mul_neg1x3");
      do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ones");
      do_op(3'd4, 32'hFFFF_FFF9, 32'd2,         "div_m7_2");
      do_op(3'd6, 32'hFFFF_FFF9, 32'd2,         "rem_m7_2");
      do_op(3'd5, 32'd100,       32'd7,         "divu_100_7");
      do_op(3'd7, 32'd100,       32'd7,         "remu_100_7");
      do_op(3'd5, 32'd5,         32'd0,         "divu_by0");
      do_op(3'd7, 32'd5,         32'd0,         "remu_by0");
      do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");

      // Flush a divide at T+10, then a multiply accepted at T+11
      @(negedge i_clk);
      i_valid = 1'b1; i_funct3 = 3'd4; i_src1 = 32'hFFFF_FFF9; i_src2 = 32'd2;
      #1;
      chk("flush/start_stall", 32'(o_stall), 32'd1);
      for (int c = 1; c < 10; c++) begin
         @(negedge i_clk);
         #1;
         chk("flush/busy_valid", 32'(o_valid), 32'd0);
      end
      @(negedge i_clk);
      i_flush = 1'b1;
      #1;
      chk("flush/stall", 32'(o_stall), 32'd0);
      chk("flush/valid", 32'(o_valid), 32'd0);
      do_op(3'd3, 32'hFFFF_FFFF, 32'd2, "mulhu_after_flush");

      // Same sequence with reset asserted at T+10
      @(negedge i_clk);
      i_valid = 1'b1; i_funct3 = 3'd4; i_src1 = 32'hFFFF_FFF9; i_src2 = 32'd2;
      for (int c = 1; c < 10; c++) @(negedge i_clk);
      #1;
      chk("rst_mid/busy_stall", 32'(o_stall), 32'd1);
      @(negedge i_clk);
      i_rst_n = 1'b0;
      #1;
      chk("rst_mid/valid", 32'(o_valid), 32'd0);
      chk("rst_mid/dout", o_dout, 32'd0);
      chk("rst_mid/stall", 32'(o_stall), 32'd0);
      last_exp = '0;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      i_valid = 1'b0;
      #1;
      chk("rst_mid/idle_valid", 32'(o_valid), 32'd0);
      do_op(3'd3, 32'hFFFF_FFFF, 32'd2, "mulhu_after_rst");

      for (int n = 0; n < 40; n++) begin
         logic [2:0] rf;
         rf = 3'($urandom_range(0, 7));
         do_op(rf, pick_operand(), pick_operand(), "rand");
      end

      @(negedge i_clk);
      i_valid = 1'b0;
      #1;
      chk("final/valid", 32'(o_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/exu_mdu_ctrl.md
# exu_mdu_ctrl

`exu_mdu_ctrl` is the RV32M sequencing stage in EX. It sits directly upstream of the combinational multiplier `exu_mul` and feeds it.
- It decodes the M-extension `funct3`, drives the multiplier's signedness and high/low select, and registers the multiplier result.
- It contains an iterative 32-cycle restoring divider for DIV/DIVU/REM/REMU.
- It stalls the pipeline until the registered result is ready.

## Interface
Parameters:
- `DATA_WIDTH`, default `` `RV32_DATA_WIDTH `` (32): operand and result width. The divider count is fixed to `DATA_WIDTH` iterations.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `i_clk`  in  1  clock.
  - `i_rst_n`  in  1  asynchronous active-low reset.
- Operation inputs from the EX stage:
  - `i_valid`  in  1  M-ext op present in EX. Held stable with its operands while `o_stall`=1.
  - `i_funct3`  in  3  M-ext op select.
  - `i_src1`, `i_src2`  in  32 each  rs1 and rs2 operands.
  - `i_flush`  in  1  kill the in-flight op.
- Multiplier drive, outputs to `exu_mul`:
  - `o_mul_src1`, `o_mul_src2`  out  32 each  equal to `i_src1` / `i_src2`.
  - `o_mul_src1_signed`, `o_mul_src2_signed`  out  1 each.
  - `o_mul_sel_high`  out  1.
- Multiplier result:
  - `i_mul_dout`  in  32  result from `exu_mul`.
- Pipeline outputs:
  - `o_stall`  out  1  hold upstream stages.
  - `o_valid`  out  1  `o_dout` holds a completed result this cycle.
  - `o_dout`  out  32  registered result.

## Operation
- `funct3` decode. Multiplier drive outputs are combinational from `i_funct3`.

| `funct3` | Op | Multiplier drive (src1 signed, src2 signed, sel_high) | Divider class |
|---|---|---|---|
| 000 | MUL | s1=1, s2=1, high=0 | — |
| 001 | MULH | 1, 1, 1 | — |
| 010 | MULHSU | 1, 0, 1 | — |
| 011 | MULHU | 0, 0, 1 | — |
| 100 | DIV | don't care | signed quotient |
| 101 | DIVU | don't care | unsigned quotient |
| 110 | REM | don't care | signed remainder |
| 111 | REMU | don't care | unsigned remainder |

- States: IDLE, DIV, DONE.
- IDLE:
  - With `i_valid`=1 and `funct3[2]`=0 (multiply): capture `i_mul_dout` into `o_dout`, then go to DONE.
  - With `i_valid`=1, `funct3[2]`=1 and divisor == 0: load `o_dout` directly, then go to DONE.
    - Quotient = 0xFFFFFFFF.
    - Remainder = dividend.
  - With `i_valid`=1, signed op, dividend == 0x80000000 and divisor == 0xFFFFFFFF: load `o_dout` directly, then go to DONE.
    - Quotient = 0x80000000.
    - Remainder = 0.
  - Any other divide: latch the following, then go to DIV.
    - |dividend| and |divisor|; absolute value is applied only for signed ops.
    - Quotient sign = sign1 XOR sign2.
    - Remainder sign = sign1.
    - op type (quotient or remainder).
    - Then clear partial remainder and cnt=0.
- DIV:
  - One restoring iteration per cycle, MSB-first.
  - Partial remainder is 33 bits: shift left, bring in the next dividend bit, trial-subtract the divisor.
  - If the result is non-negative, keep it and shift 1 into the quotient; otherwise shift 0.
  - cnt increments every cycle.
  - At cnt==31, go to DONE and load `o_dout` with the selected quotient or remainder, two's-complement negated when its sign flag is set.
- DONE: `o_valid`=1. Go to IDLE next cycle unconditionally; the op is consumed this cycle.
- `o_stall` is combinational:
  - 0 when `i_flush`=1.
  - Otherwise 1 in IDLE with `i_valid`=1.
  - 1 in DIV.
  - 0 in DONE.
- `o_valid` is (state==DONE) and is registered-state based.
- `i_flush` in any state: next state IDLE; `o_valid` is not raised for the killed op; `o_dout` is unchanged.
- Reset values:
  - State = IDLE.
  - `o_dout` = 0.
  - `o_valid` = 0.
  - Divider registers = 0.
  - `o_stall` = 0.
  - Reset mid-division aborts with no output.

## Timing
- Op accepted in cycle T (IDLE, `i_valid`=1).
- Multiply, divide-by-zero and signed overflow:
  - `o_stall`=1 in T.
  - `o_valid`=1 and `o_stall`=0 in T+1.
- Normal divide:
  - `o_stall`=1 in T through T+32; the DIV state occupies T+1..T+32.
  - `o_valid`=1 in T+33.
- Back-to-back ops: the next op is accepted in the cycle after DONE. At most one result per 2 cycles.
- `o_dout` is stable from DONE until the next load.

## Test plan
- MULH 0x80000000 × 0x80000000 at T → `o_dout`=0x40000000, `o_valid` at T+1.
- MUL 0xFFFFFFFF × 3 → `o_dout`=0xFFFFFFFD, `o_stall` high exactly 1 cycle.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF → `o_dout`=0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD at T+33, `o_stall` high T..T+32.
- REM −7 / 2 → 0xFFFFFFFF at T+33.
- DIVU 100 / 7 → 14.
- REMU 100 / 7 → 2.
- DIVU 5 / 0 → 0xFFFFFFFF at T+1.
- REMU 5 / 0 → 5 at T+1.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at T+1.
- REM of the same operands → 0 at T+1.
- DIV started at T, `i_flush` at T+10:
  - `o_valid` never asserts.
  - MULHU 0xFFFFFFFF × 2 accepted at T+11 → 0x00000001 at T+12.
  - Repeat the same sequence with `i_rst_n` low at T+10 → all outputs return to 0 immediately.
